// File: rtl/fuzz_mix_pkg.sv
// Shared widths, field offsets and helpers for the fuzz_mix mixing datapath.
// Field offsets here define the layout of the packed status vector y and of S.
package fuzz_mix_pkg;

  localparam int A_W    = 18;
  localparam int B_W    = 14;
  localparam int C_W    = 10;
  localparam int D_W    = 21;
  localparam int S_W    = 101;
  localparam int Y_W    = 421;
  localparam int CNT_W  = 28;
  localparam int ACC_W  = 32;
  localparam int SUM_W  = 23;
  localparam int PROD_W = 24;

  localparam int Y_RAW_LSB = 358;
  localparam int Y_R_LSB   = 295;
  localparam int Y_S_LSB   = 194;
  localparam int Y_SD_LSB  = 93;
  localparam int Y_ACC_LSB = 61;
  localparam int Y_CNT_LSB = 33;
  localparam int Y_CHK_LSB = 1;
  localparam int Y_PAR_LSB = 0;

  localparam int S_MX_LSB   = 0;
  localparam int S_ROT_LSB  = 14;
  localparam int S_FLG_LSB  = 32;
  localparam int S_XR_LSB   = 36;
  localparam int S_PROD_LSB = 54;
  localparam int S_SUM_LSB  = 78;

  // Rotate-left of an A-width word via a doubled copy, so no wrap logic is needed.
  function automatic logic [A_W-1:0] rotl_a(input logic [A_W-1:0] a, input logic [3:0] n);
    logic [2*A_W-1:0] dbl;
    dbl = {a, a} << n;
    return dbl[2*A_W-1:A_W];
  endfunction

endpackage

// File: rtl/fuzz_mix_stage2.sv
// Combinational mixing stage: maps the captured operands r0..r3 onto the
// 101-bit vector S (sum, prod, xr, flags, rot, mx from MSB to LSB).
module fuzz_mix_stage2
  import fuzz_mix_pkg::*;
(
  input  logic [A_W-1:0] r0_i,
  input  logic [B_W-1:0] r1_i,
  input  logic [C_W-1:0] r2_i,
  input  logic [D_W-1:0] r3_i,
  output logic [S_W-1:0] s_o
);

  logic signed [SUM_W-1:0]  a_x, b_x, c_x, d_x, sum;
  logic signed [PROD_W-1:0] b_p, c_p, prod;
  logic signed [B_W-1:0]    c_m;
  logic                     b_gt_c;
  logic [3:0]               flags;

  always_comb begin
    a_x    = {{(SUM_W-A_W){1'b0}}, r0_i};
    b_x    = {{(SUM_W-B_W){r1_i[B_W-1]}}, r1_i};
    c_x    = {{(SUM_W-C_W){r2_i[C_W-1]}}, r2_i};
    d_x    = {{(SUM_W-D_W){r3_i[D_W-1]}}, r3_i};
    sum    = a_x + b_x + c_x + d_x;
    b_p    = {{(PROD_W-B_W){r1_i[B_W-1]}}, r1_i};
    c_p    = {{(PROD_W-C_W){r2_i[C_W-1]}}, r2_i};
    prod   = b_p * c_p;
    c_m    = {{(B_W-C_W){r2_i[C_W-1]}}, r2_i};
    b_gt_c = $signed(r1_i) > c_m;
    flags  = {r3_i[D_W-1], b_gt_c, r0_i == '0, r3_i[D_W-1:3] == r0_i};

    s_o = '0;
    s_o[S_SUM_LSB  +: SUM_W]  = sum;
    s_o[S_PROD_LSB +: PROD_W] = prod;
    s_o[S_XR_LSB   +: A_W]    = r0_i ^ r3_i[A_W-1:0];
    s_o[S_FLG_LSB  +: 4]      = flags;
    s_o[S_ROT_LSB  +: A_W]    = rotl_a(r0_i, r2_i[3:0]);
    s_o[S_MX_LSB   +: B_W]    = b_gt_c ? r1_i : c_m;
  end

endmodule

// File: rtl/fuzz_mix_datapath.sv
// Two-stage mixing datapath with accumulator, checksum and cycle counter, packed into y.
// Define OUT_REG_EN to register y (one extra cycle of latency, reset value 0).
module fuzz_mix_datapath
  import fuzz_mix_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] wire0,
  input  logic [B_W-1:0] wire1,
  input  logic [C_W-1:0] wire2,
  input  logic [D_W-1:0] wire3,
  output logic [Y_W-1:0] y
);

  logic [A_W-1:0]   r0_q, r0_d;
  logic [B_W-1:0]   r1_q, r1_d;
  logic [C_W-1:0]   r2_q, r2_d;
  logic [D_W-1:0]   r3_q, r3_d;
  logic [S_W-1:0]   s_q, s_d, sd_q, sd_d;
  logic [ACC_W-1:0] acc_q, acc_d, chk_q, chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0]   y_comb;

  fuzz_mix_stage2 u_stage2 (
    .r0_i (r0_q),
    .r1_i (r1_q),
    .r2_i (r2_q),
    .r3_i (r3_q),
    .s_o  (s_d)
  );

  always_comb begin
    r0_d  = wire0;
    r1_d  = wire1;
    r2_d  = wire2;
    r3_d  = wire3;
    sd_d  = s_q;
    acc_d = acc_q + {{(ACC_W-SUM_W){s_q[S_SUM_LSB+SUM_W-1]}}, s_q[S_SUM_LSB +: SUM_W]};
    chk_d = {chk_q[ACC_W-2:0], chk_q[ACC_W-1]} ^ {{(ACC_W-A_W){1'b0}}, s_q[S_XR_LSB +: A_W]};
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      s_q   <= '0;
      sd_q  <= '0;
      acc_q <= '0;
      chk_q <= '0;
      cnt_q <= '0;
    end else begin
      r0_q  <= r0_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      s_q   <= s_d;
      sd_q  <= sd_d;
      acc_q <= acc_d;
      chk_q <= chk_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    y_comb = '0;
    y_comb[Y_RAW_LSB +: 63]    = {wire3, wire2, wire1, wire0};
    y_comb[Y_R_LSB   +: 63]    = {r3_q, r2_q, r1_q, r0_q};
    y_comb[Y_S_LSB   +: S_W]   = s_q;
    y_comb[Y_SD_LSB  +: S_W]   = sd_q;
    y_comb[Y_ACC_LSB +: ACC_W] = acc_q;
    y_comb[Y_CNT_LSB +: CNT_W] = cnt_q;
    y_comb[Y_CHK_LSB +: ACC_W] = chk_q;
    y_comb[Y_PAR_LSB]          = ^s_q;
  end

`ifdef OUT_REG_EN
  logic [Y_W-1:0] y_q, y_d;

  always_comb y_d = y_comb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y = y_q;
`else
  assign y = y_comb;
`endif

endmodule

// File: tb/tb_fuzz_mix_datapath.sv
// Self-checking bench for fuzz_mix_datapath: directed cases plus random vectors
// against an arithmetic reference model; honours OUT_REG_EN for the extra y stage.
module tb_fuzz_mix_datapath;

`ifdef OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk;
  logic          rst;
  logic [17:0]   w0;
  logic [13:0]   w1;
  logic [9:0]    w2;
  logic [20:0]   w3;
  logic [420:0]  y;

  int checks = 0;
  int errors = 0;

  logic [17:0]         m_r0;
  logic signed [13:0]  m_r1;
  logic signed [9:0]   m_r2;
  logic signed [20:0]  m_r3;
  logic [100:0]        m_s, m_sd;
  logic [31:0]         m_acc, m_chk;
  logic [27:0]         m_cnt;
  logic [420:0]        m_yreg;

  fuzz_mix_datapath dut (
    .clk   (clk),
    .rst   (rst),
    .wire0 (w0),
    .wire1 (w1),
    .wire2 (w2),
    .wire3 (w3),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // S computed from the operand rules using plain integer arithmetic.
  function automatic logic [100:0] s_of(input logic [17:0] r0, input logic signed [13:0] r1,
                                        input logic signed [9:0] r2, input logic signed [20:0] r3);
    int a, b, c, d, n;
    logic [31:0] sum, prod;
    logic [35:0] dbl;
    logic [17:0] rot;
    logic [13:0] mx;
    logic [3:0]  fl;
    a    = int'(r0);
    b    = r1;
    c    = r2;
    d    = r3;
    sum  = a + b + c + d;
    prod = b * c;
    n    = c & 15;
    dbl  = {r0, r0} << n;
    rot  = dbl[35:18];
    mx   = 14'((b > c) ? b : c);
    fl   = {d < 0, b > c, a == 0, ((d >> 3) & 'h3FFFF) == a};
    return {sum[22:0], prod[23:0], r0 ^ r3[17:0], fl, rot, mx};
  endfunction

  function automatic logic [420:0] model_y();
    return {w3, w2, w1, w0, m_r3, m_r2, m_r1, m_r0, m_s, m_sd, m_acc, m_cnt, m_chk, ^m_s};
  endfunction

  function automatic logic [420:0] exp_y();
`ifdef OUT_REG_EN
    return m_yreg;
`else
    return model_y();
`endif
  endfunction

  task automatic model_reset();
    m_r0 = '0; m_r1 = '0; m_r2 = '0; m_r3 = '0;
    m_s = '0; m_sd = '0; m_acc = '0; m_chk = '0; m_cnt = '0; m_yreg = '0;
  endtask

  task automatic model_step();
    logic [100:0]       ns;
    logic signed [22:0] sm;
    int                 si;
    ns    = s_of(m_r0, m_r1, m_r2, m_r3);
    sm    = m_s[100:78];
    si    = sm;
    m_acc = m_acc + si;
    m_chk = {m_chk[30:0], m_chk[31]} ^ {14'b0, m_s[53:36]};
    m_sd  = m_s;
    m_s   = ns;
    m_cnt = m_cnt + 28'd1;
    m_r0  = w0;
    m_r1  = w1;
    m_r2  = w2;
    m_r3  = w3;
  endtask

  task automatic check(input string tag, input logic [420:0] obs, input logic [420:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [420:0] pre;
    pre = model_y();
    @(posedge clk);
    model_step();
    m_yreg = pre;
    #1;
    check("y_edge", y, exp_y());
  endtask

  task automatic set_in(input logic [17:0] a, input logic [13:0] b, input logic [9:0] c, input logic [20:0] d);
    w0 = a; w1 = b; w2 = c; w3 = d;
  endtask

  logic [100:0] s_exp_a;

  initial begin
    rst = 1'b1;
    set_in('0, '0, '0, '0);
    model_reset();
    #22;
    check("reset_y", y, '0);
    rst = 1'b0;

    for (int i = 0; i < 5 + LAT; i++) tick();
    check("cnt_5", y[60:33], 421'(28'd5));
    check("acc_zero", y[92:61], '0);
    check("chk_zero", y[32:1], '0);

    set_in(18'h00001, 14'h3FFF, 10'h002, 21'h1FFFFC);
    for (int i = 0; i < 2 + LAT; i++) tick();
    check("sum_a",   y[294:272], 421'(23'h7FFFFE));
    check("prod_a",  y[271:248], 421'(24'hFFFFFE));
    check("xr_a",    y[247:230], 421'(18'h3FFFD));
    check("flags_a", y[229:226], 421'(4'b1000));
    check("rot_a",   y[225:208], 421'(18'h00004));
    check("mx_a",    y[207:194], 421'(14'h0002));
    tick();
    s_exp_a = {23'h7FFFFE, 24'hFFFFFE, 18'h3FFFD, 4'b1000, 18'h00004, 14'h0002};
    check("acc_a", y[92:61], 421'(32'hFFFFFFFE));
    check("sd_a",  y[193:93], 421'(s_exp_a));
    check("chk_a", y[32:1], 421'(32'h0003FFFD));

    set_in(18'h20000, 14'h0000, 10'h00F, 21'h000000);
    for (int i = 0; i < 2 + LAT; i++) tick();
    check("rot_b",   y[225:208], 421'(18'h04000));
    check("flags_b", y[229:226], 421'(4'b0000));

    for (int i = 0; i < 30; i++) begin
      set_in(18'($urandom), 14'($urandom), 10'($urandom), 21'($urandom));
      tick();
    end

    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_regs", y[357:0], '0);
    check("async_rst_y", y, exp_y());
    #2;
    rst = 1'b0;
    for (int i = 0; i < 1 + LAT; i++) begin
      set_in(18'($urandom), 14'($urandom), 10'($urandom), 21'($urandom));
      tick();
    end
    check("cnt_restart", y[60:33], 421'(28'd1));

    for (int i = 0; i < 20; i++) begin
      set_in(18'($urandom), 14'($urandom), 10'($urandom), 21'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
